spi_regbank_peripheral: RTL and testbench
=========================================

Name: spi_regbank_peripheral

Overview:
Parametrised successor to the onboarding SPI write-only register peripheral. It is an SPI mode-0 target with a configurable register bank, and it supports both writes and read-back over CIPO. It also adds frame-length checking, address-range checking and a write-notify strobe. It sits between the chip-level SPI pins and the PWM/output-enable logic, which consume the flattened register bus.

Parameters:
NUM_REGS, 5, number of implemented registers (addresses 0..NUM_REGS-1)
DATA_W, 8, register and data-field width in bits
ADDR_W, 7, address-field width in bits; frame length FRAME_W = 1+ADDR_W+DATA_W (default 16)
SYNC_STAGES, 2, flip-flop depth of the input synchroniser (minimum 2)
RESET_VAL, 0, reset value applied to every register

Ports:
clk  input  1  system clock; all logic is on its rising edge
rst  input  1  asynchronous, active-high reset
spi_sclk  input  1  SPI clock, asynchronous to clk, CPOL=0
spi_copi  input  1  controller-out data, sampled on sclk rising edge
spi_cs  input  1  chip select, active low
spi_cipo  output  1  peripheral-out data, changes on sclk falling edge
spi_cipo_oe  output  1  high while the synchronised CS is low
regs_out  output  NUM_REGS*DATA_W  flattened register bank; register i occupies [i*DATA_W +: DATA_W]
wr_valid  output  1  one-cycle pulse when a register is updated
wr_addr  output  ADDR_W  address of the last committed write
frame_err  output  1  one-cycle pulse when a frame is rejected for bad length
addr_err  output  1  one-cycle pulse for an out-of-range access of correct length

Behaviour:
- Reset (async on rst high, released synchronously):
  - all registers = RESET_VAL
  - all outputs = 0
  - synchronisers = sclk 0, cs 1, copi 0
  - FSM = IDLE
  - any partial frame is discarded
- Synchronisation and edge detection:
  - sclk, cs and copi each pass through SYNC_STAGES flip-flops.
  - Edges are detected from the last two stages.
  - Input-to-action latency is SYNC_STAGES+1 clk cycles.
  - sclk must be slower than clk/4.
- Frame format, MSB first: bit0 rw (1 = write, 0 = read), then ADDR_W address bits, then DATA_W data bits.
- FSM states: IDLE, CMD, DATA, OVER.
  - IDLE -> CMD on CS falling; bit counter cleared, shift register cleared.
  - CMD: each sclk rising shifts copi in. After 1+ADDR_W bits -> DATA; rw and address are latched.
  - DATA: each sclk rising shifts copi in. After DATA_W bits the frame is complete and the FSM stays in DATA.
  - DATA -> OVER on any further sclk rising.
  - OVER: further bits are ignored until CS rises.
  - Any state -> IDLE on CS rising.
- Commit on CS rising (evaluated in the cycle the edge is detected):
  - Exactly FRAME_W bits, write, address < NUM_REGS: register updated and wr_valid=1 in the next cycle; wr_addr updated in the same cycle.
  - Exactly FRAME_W bits, address >= NUM_REGS (read or write): no update, addr_err pulse.
  - Exactly FRAME_W bits, read, address in range: no side effects.
  - Bit count != FRAME_W (short, or OVER): frame_err pulse; no update, even if the data field was complete.
- Read path:
  - On entry to DATA with rw=0, the output shift register loads regs[addr], or all-zero if out of range.
  - On each sclk falling detected while in DATA, spi_cipo presents the next bit, MSB first. The first falling after the last address bit presents the MSB.
  - spi_cipo = 0 in IDLE, CMD and OVER, and during write frames.
- sclk edges while CS is high are ignored.
- CS pulses with zero sclk edges produce frame_err.
- Simultaneous CS rising and sclk rising in the same clk cycle: CS wins, and the sclk edge is not counted.
- A write to a register and a readback in the following frame return the new value; there are no read-during-write hazards within one frame.

Test Plan:
- Write 0xAA to address 0x02 (frame 0x82AA), CS high -> regs_out[23:16]=0xAA after SYNC_STAGES+2 cycles; wr_valid one pulse; wr_addr=0x02; other registers 0.
- Write 0x5C to address 0x04, then read address 0x04 (frame 0x0400) -> cipo bits 0,1,0,1,1,1,0,0 captured on the 8 data rising edges; no wr_valid on the read.
- Write to address 0x10 (frame 0x90FF) -> addr_err pulse; regs_out unchanged; no wr_valid. A read of 0x10 returns 0x00 and pulses addr_err.
- Length errors:
  - Raise CS after 12 bits of a 0x81F0 write -> frame_err; register 1 stays 0.
  - A 17-bit frame -> frame_err; no update.
- Assert rst after 10 bits of a write, release, then send a full write of 0x33 to address 0x00 -> only 0x33 is committed; all other registers are RESET_VAL.
- Toggle sclk 16 times with CS high, then run a normal write -> the toggles are ignored and the write commits correctly; also re-run with DATA_W=16, ADDR_W=4, NUM_REGS=8 (21-bit frames).

Source files
------------

// File: rtl/spi_regbank_peripheral.sv
// SPI mode-0 target with a read/write register bank, frame-length and address-range checks.
// Latency: pins pass a SYNC_STAGES-deep synchroniser; commit/err pulses land one cycle after CS rise is seen.
// Backpressure: none; sclk must run slower than clk/4 or edges are lost.
// Ports: clk/rst (async active-high); spi_sclk/spi_copi/spi_cs in; spi_cipo/spi_cipo_oe out;
//        regs_out flattened bank (reg i at [i*DATA_W +: DATA_W]); wr_valid/wr_addr write notify;
//        frame_err (bad bit count) and addr_err (address >= NUM_REGS) one-cycle pulses.
module spi_regbank_peripheral #(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2,  // must be at least 2
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       spi_sclk,
  input  logic                       spi_copi,
  input  logic                       spi_cs,
  output logic                       spi_cipo,
  output logic                       spi_cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_valid,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err,
  output logic                       addr_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam int SH_W    = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_W);
  localparam logic [ADDR_W:0]   NREGS     = (ADDR_W+1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, CMD, DATA, OVER} state_t;
  state_t state, state_next;

  // Synchronisers: stage 0 is nearest the pin, stage SYNC_STAGES-1 the oldest.
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, copi_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      copi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi_copi};
    end
  end

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, copi_bit;
  assign sclk_rise = sclk_sync[SYNC_STAGES-2] & ~sclk_sync[SYNC_STAGES-1];
  assign sclk_fall = ~sclk_sync[SYNC_STAGES-2] & sclk_sync[SYNC_STAGES-1];
  assign cs_rise   = cs_sync[SYNC_STAGES-2] & ~cs_sync[SYNC_STAGES-1];
  assign cs_fall   = ~cs_sync[SYNC_STAGES-2] & cs_sync[SYNC_STAGES-1];
  assign copi_bit  = copi_sync[SYNC_STAGES-1];

  logic [CNT_W-1:0]          bit_cnt;
  logic [SH_W-1:0]           shift;
  logic [DATA_W-1:0]         tx_shift;
  logic                      cipo_q;
  logic                      lat_rw;
  logic [ADDR_W-1:0]         lat_addr;
  logic [NUM_REGS*DATA_W-1:0] regs_q;

  // A CS rise in the same cycle as an sclk rise ends the frame; that bit is dropped.
  logic bit_take, cmd_done, addr_ok;
  logic [ADDR_W:0]   cmd_word;   // rw bit followed by the address, as it completes
  logic [DATA_W-1:0] rd_val;

  assign bit_take = sclk_rise & ~cs_rise & ((state == CMD) | (state == DATA));
  assign cmd_word = {shift[ADDR_W-1:0], copi_bit};
  assign cmd_done = bit_take & (state == CMD) & (bit_cnt == CMD_LAST);
  assign addr_ok  = {1'b0, lat_addr} < NREGS;

  // Read mux; out-of-range addresses fall through to zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cmd_word[ADDR_W-1:0] == ADDR_W'(i)) rd_val = regs_q[i*DATA_W +: DATA_W];
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    if (cs_rise) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (cs_fall) state_next = CMD;
        CMD:     if (cmd_done) state_next = DATA;
        DATA:    if (sclk_rise && bit_cnt == FRAME_CNT) state_next = OVER;
        OVER:    state_next = OVER;
        default: state_next = IDLE;
      endcase
    end
  end

  // FSM: outputs. CIPO only drives data during the data phase of a read frame.
  always_comb begin
    spi_cipo    = (state == DATA) & ~lat_rw & cipo_q;
    spi_cipo_oe = ~cs_sync[SYNC_STAGES-1];
    regs_out    = regs_q;
  end

  // Datapath: shift-in, read shift-out and commit on CS rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      shift     <= '0;
      tx_shift  <= '0;
      cipo_q    <= 1'b0;
      lat_rw    <= 1'b0;
      lat_addr  <= '0;
      regs_q    <= {NUM_REGS{RESET_VAL}};
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;
      addr_err  <= 1'b0;

      if (state == IDLE && cs_fall) begin
        bit_cnt <= '0;
        shift   <= '0;
      end else if (bit_take) begin
        bit_cnt <= bit_cnt + 1'b1;
        shift   <= {shift[SH_W-2:0], copi_bit};
      end

      if (cmd_done) begin
        lat_rw   <= cmd_word[ADDR_W];
        lat_addr <= cmd_word[ADDR_W-1:0];
        tx_shift <= cmd_word[ADDR_W] ? '0 : rd_val;
        cipo_q   <= 1'b0;
      end else if (state == DATA && sclk_fall) begin
        cipo_q   <= tx_shift[DATA_W-1];
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end

      // Only a frame sitting in DATA with exactly FRAME_W bits is a valid access.
      if (cs_rise && state != IDLE) begin
        if (state == DATA && bit_cnt == FRAME_CNT) begin
          if (!addr_ok) begin
            addr_err <= 1'b1;
          end else if (lat_rw) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (lat_addr == ADDR_W'(i)) regs_q[i*DATA_W +: DATA_W] <= shift[DATA_W-1:0];
            end
            wr_valid <= 1'b1;
            wr_addr  <= lat_addr;
          end
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_regbank_peripheral.sv
// Bench for spi_regbank_peripheral: two instances (default 16-bit frames, and 21-bit frames).
// Frames are driven bit by bit; an event model predicts each commit/error pulse and the bank contents.
// A per-cycle compare process checks pulses, wr_addr, pulse latency and regs_out against the model.
module tb_spi_regbank_peripheral;

  localparam int H = 6;  // sclk half period in clk cycles

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic sclk0, copi0, cs0, cipo0, oe0, wv0, fe0, ae0;
  logic [39:0] ro0;
  logic [6:0]  wa0;
  logic sclk1, copi1, cs1, cipo1, oe1, wv1, fe1, ae1;
  logic [127:0] ro1;
  logic [3:0]   wa1;

  spi_regbank_peripheral dut0 (
    .clk(clk), .rst(rst), .spi_sclk(sclk0), .spi_copi(copi0), .spi_cs(cs0),
    .spi_cipo(cipo0), .spi_cipo_oe(oe0), .regs_out(ro0), .wr_valid(wv0),
    .wr_addr(wa0), .frame_err(fe0), .addr_err(ae0)
  );

  spi_regbank_peripheral #(
    .NUM_REGS(8), .DATA_W(16), .ADDR_W(4), .SYNC_STAGES(2), .RESET_VAL(16'h0000)
  ) dut1 (
    .clk(clk), .rst(rst), .spi_sclk(sclk1), .spi_copi(copi1), .spi_cs(cs1),
    .spi_cipo(cipo1), .spi_cipo_oe(oe1), .regs_out(ro1), .wr_valid(wv1),
    .wr_addr(wa1), .frame_err(fe1), .addr_err(ae1)
  );

  typedef struct {
    int kind;  // 1 write, 2 addr_err, 3 frame_err
    int addr;
    int data;
    int t;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  logic [39:0]  m0;
  logic [127:0] m1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nwv[2];
  int nae[2];
  int nfe[2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int aw(input int sel); return (sel != 0) ? 4 : 7; endfunction
  function automatic int dw(input int sel); return (sel != 0) ? 16 : 8; endfunction
  function automatic int nr(input int sel); return (sel != 0) ? 8 : 5; endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int sel, input logic s, input logic c, input logic n);
    if (sel == 0) begin sclk0 = s; copi0 = c; cs0 = n; end
    else          begin sclk1 = s; copi1 = c; cs1 = n; end
  endtask

  // Checks one DUT's pulses against the expected-event queue and applies writes to the model.
  task automatic cmp(input int sel, input logic wv, input logic ae, input logic fe, input int wa);
    ev_t e;
    int kind;
    int lat;
    kind = wv ? 1 : (ae ? 2 : (fe ? 3 : 0));
    if (kind == 0) return;
    if (wv) nwv[sel]++;
    if (ae) nae[sel]++;
    if (fe) nfe[sel]++;
    chk("single_pulse_kind", 128'(int'(wv) + int'(ae) + int'(fe)), 128'd1);
    checks++;
    if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
      errors++;
      $display("FAIL unexpected_pulse dut%0d: got pulse kind %0d, expected no pulse", sel, kind);
      return;
    end
    if (sel == 0) e = q0.pop_front();
    else          e = q1.pop_front();
    chk("pulse_kind", 128'(kind), 128'(e.kind));
    lat = cyc - e.t;
    checks++;
    if (lat < 2 || lat > 4) begin
      errors++;
      $display("FAIL pulse_latency dut%0d: got %0d cycles, expected 2..4", sel, lat);
    end
    if (kind == 1) begin
      chk("wr_addr", 128'(wa), 128'(e.addr));
      if (sel == 0) m0[e.addr*8 +: 8]   = 8'(e.data);
      else          m1[e.addr*16 +: 16] = 16'(e.data);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cmp(0, wv0, ae0, fe0, int'(wa0));
      cmp(1, wv1, ae1, fe1, int'(wa1));
      chk("regs_out0", 128'(ro0), 128'(m0));
      chk("regs_out1", ro1, m1);
    end
  end

  // Drives one frame of nbits (MSB first); captures CIPO just before each sclk rise.
  task automatic frame(input int sel, input int nbits, input logic [31:0] bits,
                       input bit raise, output logic [31:0] rd);
    int fw, a, d, rw, exp_rd;
    ev_t e;
    fw = 1 + aw(sel) + dw(sel);
    rw = int'(bits >> (fw - 1)) & 1;
    a  = int'(bits >> dw(sel)) & ((1 << aw(sel)) - 1);
    d  = int'(bits) & ((1 << dw(sel)) - 1);
    exp_rd = 0;
    if (a < nr(sel)) exp_rd = (sel == 0) ? int'(m0[a*8 +: 8]) : int'(m1[a*16 +: 16]);
    rd = '0;
    drive(sel, 1'b0, 1'b0, 1'b0);
    wait_clk(H);
    chk("cipo_oe_in_frame", 128'((sel == 0) ? oe0 : oe1), 128'd1);
    for (int i = 0; i < nbits; i++) begin
      drive(sel, 1'b0, bits[nbits-1-i], 1'b0);
      wait_clk(H);
      rd = {rd[30:0], ((sel == 0) ? cipo0 : cipo1)};
      drive(sel, 1'b1, bits[nbits-1-i], 1'b0);
      wait_clk(H);
    end
    drive(sel, 1'b0, 1'b0, 1'b0);
    wait_clk(H);
    if (raise) begin
      drive(sel, 1'b0, 1'b0, 1'b1);
      e.addr = a; e.data = d; e.t = cyc;
      if (nbits != fw)      e.kind = 3;
      else if (a >= nr(sel)) e.kind = 2;
      else if (rw == 1)      e.kind = 1;
      else                   e.kind = 0;
      if (e.kind != 0) begin
        if (sel == 0) q0.push_back(e);
        else          q1.push_back(e);
      end
      wait_clk(H);
      if (nbits == fw && rw == 0) begin
        chk("read_data", 128'(int'(rd) & ((1 << dw(sel)) - 1)), 128'(exp_rd));
        chk("cipo_cmd_phase", 128'(rd >> dw(sel)), 128'd0);
      end else if (nbits == fw) begin
        chk("cipo_write_frame", 128'(rd), 128'd0);
      end
    end
  endtask

  task automatic drain(input int sel);
    int n;
    n = 0;
    while (((sel == 0) ? q0.size() : q1.size()) != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout dut%0d: got %0d pending events, expected 0", sel,
               (sel == 0) ? q0.size() : q1.size());
      if (sel == 0) q0.delete();
      else          q1.delete();
    end
    wait_clk(4);
  endtask

  task automatic toggles(input int sel);
    for (int i = 0; i < 16; i++) begin
      drive(sel, 1'b1, 1'(i & 1), 1'b1);
      wait_clk(H);
      drive(sel, 1'b0, 1'b0, 1'b1);
      wait_clk(H);
    end
    wait_clk(4);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int wv_base;
    m0 = '0;
    m1 = '0;
    for (int i = 0; i < 2; i++) begin nwv[i] = 0; nae[i] = 0; nfe[i] = 0; end
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b1);
    drive(1, 1'b0, 1'b0, 1'b1);
    wait_clk(4);
    chk("rst_regs0", 128'(ro0), 128'd0);
    chk("rst_outs0", 128'({wv0, ae0, fe0, cipo0, oe0, wa0}), 128'd0);
    chk("rst_regs1", ro1, 128'd0);
    chk("rst_outs1", 128'({wv1, ae1, fe1, cipo1, oe1, wa1}), 128'd0);
    rst = 1'b0;
    wait_clk(4);

    // Single write to address 2
    frame(0, 16, 32'h82AA, 1'b1, rd); drain(0);
    chk("t1_reg2", 128'(ro0[23:16]), 128'hAA);
    chk("t1_wr_addr", 128'(wa0), 128'h02);
    chk("t1_bank", 128'(ro0), 128'h00_00_AA_00_00);
    chk("t1_wv_count", 128'(nwv[0]), 128'd1);

    // Write then read back address 4
    frame(0, 16, 32'h845C, 1'b1, rd); drain(0);
    frame(0, 16, 32'h0400, 1'b1, rd); drain(0);
    chk("t2_read_5c", 128'(rd[7:0]), 128'h5C);
    chk("t2_wv_count", 128'(nwv[0]), 128'd2);

    // Out-of-range write and read
    frame(0, 16, 32'h90FF, 1'b1, rd); drain(0);
    chk("t3_addr_err", 128'(nae[0]), 128'd1);
    chk("t3_bank", 128'(ro0), 128'h5C_00_AA_00_00);
    chk("t3_wv_count", 128'(nwv[0]), 128'd2);
    frame(0, 16, 32'h1000, 1'b1, rd); drain(0);
    chk("t3_read_oob", 128'(rd[7:0]), 128'h00);
    chk("t3_addr_err2", 128'(nae[0]), 128'd2);

    // Length errors: short, long, and an empty CS pulse
    frame(0, 12, 32'h81F, 1'b1, rd); drain(0);
    chk("t4_short_fe", 128'(nfe[0]), 128'd1);
    chk("t4_reg1", 128'(ro0[15:8]), 128'h00);
    frame(0, 17, 32'h106AB, 1'b1, rd); drain(0);
    chk("t4_long_fe", 128'(nfe[0]), 128'd2);
    chk("t4_reg3", 128'(ro0[31:24]), 128'h00);
    frame(0, 0, 32'h0, 1'b1, rd); drain(0);
    chk("t4_empty_fe", 128'(nfe[0]), 128'd3);
    chk("t4_wv_count", 128'(nwv[0]), 128'd2);

    // Reset in the middle of a write, then a clean write
    frame(0, 10, 32'h209, 1'b0, rd);
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b1);
    m0 = '0;
    m1 = '0;
    q0.delete();
    q1.delete();
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);
    chk("t5_bank_after_rst", 128'(ro0), 128'd0);
    frame(0, 16, 32'h8033, 1'b1, rd); drain(0);
    chk("t5_bank", 128'(ro0), 128'h00_00_00_00_33);

    // sclk activity with CS high is ignored
    wv_base = nwv[0];
    toggles(0);
    chk("t6_no_pulse", 128'(nwv[0] + nae[0] + nfe[0]), 128'(wv_base + 2 + 3));
    frame(0, 16, 32'h8177, 1'b1, rd); drain(0);
    chk("t6_bank", 128'(ro0), 128'h00_00_00_77_33);

    // 21-bit frame instance
    toggles(1);
    frame(1, 21, 32'h15BEEF, 1'b1, rd); drain(1);
    chk("d1_reg5", 128'(ro1[95:80]), 128'hBEEF);
    chk("d1_wr_addr", 128'(wa1), 128'h5);
    frame(1, 21, 32'h050000, 1'b1, rd); drain(1);
    chk("d1_read", 128'(rd[15:0]), 128'hBEEF);
    frame(1, 21, 32'h191234, 1'b1, rd); drain(1);
    chk("d1_addr_err", 128'(nae[1]), 128'd1);
    chk("d1_bank", ro1, 128'hBEEF << 80);
    frame(1, 16, 32'hFFFF, 1'b1, rd); drain(1);
    chk("d1_short_fe", 128'(nfe[1]), 128'd1);
    chk("d1_wv_count", 128'(nwv[1]), 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
